udp_payload_framer: RTL and testbench
=====================================

Name: udp_payload_framer

Overview:
- TX counterpart of the RX UDP extractor: builds a complete Ethernet/IPv4/UDP frame around payload bytes drained from a first-word-fall-through (FWFT) FIFO and streams it byte-wise to the MAC TX AXI-Stream.
- Frame layout: 42-byte header, then a 3-byte response opcode, then N payload bytes, then zero-padding up to the 60-byte minimum frame. The MAC appends the FCS.
- Used for order-book dump responses back to the host script.

Parameters:
DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC
SRC_MAC, 48'h0200_0000_0032, FPGA MAC
SRC_IP, {8'd192,8'd168,8'd1,8'd50}, FPGA IP
DST_IP, {8'd192,8'd168,8'd1,8'd10}, host IP
SRC_PORT, 16'd55556, UDP source port
DST_PORT, 16'd55555, UDP destination port (host script)
OPCODE, 24'hA0B0C0, response opcode prefixed to payload
MAX_PAYLOAD, 1469, largest N (1500 − 20 − 8 − 3)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to send one frame
payload_len  in  11  N, sampled when start is accepted
busy  out  1  high from accepted start until the cycle after the tlast handshake
fifo_dout  in  8  FWFT data; valid whenever !fifo_empty
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  pop; combinational = (state==PAYLOAD && !fifo_empty && m_axis_tready)
m_axis_tdata  out  8  frame byte
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  MAC ready
m_axis_tlast  out  1  last frame byte

Behaviour:
- Reset values: busy=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, state=IDLE, ip_id=16'h0000.
- start is accepted only in IDLE. In any other state it is ignored (no queueing).
- payload_len > MAX_PAYLOAD is clamped to MAX_PAYLOAD.
- Handshake: a byte transfers when tvalid && tready.
  - tdata, tvalid and tlast stay stable while tvalid && !tready.
  - tvalid must not be retracted without a transfer, except in PAYLOAD when the FIFO runs empty (see below) or on rst.
- States and transitions:
  - IDLE → CSUM on accepted start: latch N, ip_len = 31+N, udp_len = 11+N.
  - CSUM (2 cycles, tvalid=0):
    - Cycle 1: 32-bit sum of the ten IPv4 header 16-bit words, with the checksum word taken as 0.
    - Cycle 2: fold carries twice, invert → ip_csum.
  - HDR: emit bytes 0–41.
  - OPC: emit bytes 42–44.
  - PAYLOAD: emit N FIFO bytes.
  - PAD: emit 0x00 until byte 59. Entered only when 45+N < 60.
  - Back to IDLE after the tlast handshake.
- First tvalid appears 3 cycles after the start cycle.
- Byte map:
  - 0–5 DST_MAC
  - 6–11 SRC_MAC
  - 12–13 0x0800
  - 14 0x45
  - 15 0x00
  - 16–17 ip_len
  - 18–19 ip_id
  - 20–21 0x4000 (DF)
  - 22 0x40 (TTL)
  - 23 0x11 (UDP)
  - 24–25 ip_csum
  - 26–29 SRC_IP
  - 30–33 DST_IP
  - 34–35 SRC_PORT
  - 36–37 DST_PORT
  - 38–39 udp_len
  - 40–41 0x0000 (UDP checksum disabled)
  - 42–44 OPCODE, MSB first
  - 45.. payload, then pad
- All multi-byte fields are big-endian.
- Frame length = max(45+N, 60). tlast is asserted on the final byte only.
- Byte counter is 11 bits; it resets to 0 on entry to HDR.
- PAYLOAD stall: if fifo_empty, tvalid=0 and the state holds. The frame is not aborted and tlast is not forced. Streaming resumes when data arrives.
- N=0 is legal: 45 header/opcode bytes + 15 pad bytes.
- ip_id increments by 1 (mod 2^16) on each tlast handshake.
- rst mid-frame: tvalid drops the next edge, the frame is truncated without tlast, and ip_id returns to 0. The downstream MAC discards the runt.
- The block does not check how many bytes are in the FIFO. Upstream guarantees that N bytes will eventually be written.

Test Plan:
- start with N=4, FIFO preloaded {11,22,33,44}, tready=1:
  - Frame is 60 bytes; tlast on byte 59.
  - Bytes 16–17 = 0x0023; bytes 38–39 = 0x000F.
  - Bytes 42–48 = A0 B0 C0 11 22 33 44; bytes 49–59 = 0x00.
  - First tvalid 3 cycles after start.
- N=100, incrementing payload:
  - Frame is 145 bytes; tlast on byte 144.
  - IP length = 0x0083; UDP length = 0x006F.
  - Ones'-complement sum of bytes 14–33 as 16-bit words = 0xFFFF.
  - Exactly 100 fifo_rd_en pulses.
- tready toggled randomly, 50% duty, N=20: output byte sequence is identical to the tready=1 run; tdata/tvalid/tlast are stable during stalls.
- N=8 with the FIFO holding 3 bytes, remaining 5 written 20 cycles later:
  - tvalid low during the gap.
  - Frame completes correctly with no extra or missing bytes.
- Two back-to-back frames, plus a start pulsed mid-frame:
  - Mid-frame start is ignored.
  - ip_id = 0x0000 then 0x0001.
  - busy falls between frames.
- rst asserted at byte 30 of a frame:
  - tvalid=0 and busy=0 after the edge; no tlast emitted.
  - Next start produces a correct frame with ip_id=0x0000.

Source files
------------

// File: rtl/udp_payload_framer_if.sv
// Signal bundle between the UDP response framer, its payload FIFO and the MAC TX stream.
// The master modport is the framer side; the slave modport is the surrounding logic.
interface udp_payload_framer_if;
    logic        start;
    logic [10:0] payload_len;
    logic        busy;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        input  start, payload_len, fifo_dout, fifo_empty, m_axis_tready,
        output busy, fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output start, payload_len, fifo_dout, fifo_empty, m_axis_tready,
        input  busy, fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/udp_payload_framer.sv
// Wraps FIFO payload bytes in an Ethernet/IPv4/UDP frame (42-byte header, 3-byte opcode,
// payload, zero pad to 60 bytes) and streams it byte-wise to the MAC TX AXI-Stream.
module udp_payload_framer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0032,
    parameter logic [31:0] SRC_IP      = {8'd192, 8'd168, 8'd1, 8'd50},
    parameter logic [31:0] DST_IP      = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] SRC_PORT    = 16'd55556,
    parameter logic [15:0] DST_PORT    = 16'd55555,
    parameter logic [23:0] OPCODE      = 24'hA0B0C0,
    parameter int unsigned MAX_PAYLOAD = 1469
) (
    input  logic                 clk,
    input  logic                 rst,
    udp_payload_framer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CSUM1, CSUM2, HDR, OPC, PAYLOAD, PAD} state_t;

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] HDR_LAST = 11'd41;
    localparam logic [10:0] OPC_LAST = 11'd44;
    localparam logic [10:0] MIN_LAST = 11'd59;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [10:0] nLen_q, nLen_d;
    logic [10:0] lastIdx_q, lastIdx_d;
    logic [15:0] ipLen_q, ipLen_d;
    logic [15:0] udpLen_q, udpLen_d;
    logic [15:0] ipId_q, ipId_d;
    logic [15:0] csum_q, csum_d;
    logic [31:0] sum_q, sum_d;

    logic [10:0]  lenClamped;
    logic [16:0]  fold1;
    logic [15:0]  fold2;
    logic [335:0] hdrVec;
    logic [7:0]   hdrByte;
    logic [7:0]   opcByte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nLen_q    <= '0;
            lastIdx_q <= '0;
            ipLen_q   <= '0;
            udpLen_q  <= '0;
            ipId_q    <= '0;
            csum_q    <= '0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nLen_q    <= nLen_d;
            lastIdx_q <= lastIdx_d;
            ipLen_q   <= ipLen_d;
            udpLen_q  <= udpLen_d;
            ipId_q    <= ipId_d;
            csum_q    <= csum_d;
            sum_q     <= sum_d;
        end
    end

    // The header is one big-endian vector; byte k is selected by shifting it up k bytes.
    always_comb begin
        lenClamped = (bus.payload_len > MAX_LEN) ? MAX_LEN : bus.payload_len;
        fold1      = {1'b0, sum_q[31:16]} + {1'b0, sum_q[15:0]};
        fold2      = fold1[15:0] + {15'd0, fold1[16]};
        hdrVec     = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, ipLen_q, ipId_q,
                      16'h4000, 16'h4011, csum_q, SRC_IP, DST_IP,
                      SRC_PORT, DST_PORT, udpLen_q, 16'h0000};
        hdrByte    = 8'((hdrVec << {cnt_q, 3'b000}) >> 328);
        case (cnt_q)
            11'd42:  opcByte = OPCODE[23:16];
            11'd43:  opcByte = OPCODE[15:8];
            default: opcByte = OPCODE[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nLen_d    = nLen_q;
        lastIdx_d = lastIdx_q;
        ipLen_d   = ipLen_q;
        udpLen_d  = udpLen_q;
        ipId_d    = ipId_q;
        csum_d    = csum_q;
        sum_d     = sum_q;

        bus.busy          = (state_q != IDLE);
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = 8'h00;
        bus.m_axis_tlast  = 1'b0;
        bus.fifo_rd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nLen_d    = lenClamped;
                    ipLen_d   = 16'd31 + {5'd0, lenClamped};
                    udpLen_d  = 16'd11 + {5'd0, lenClamped};
                    lastIdx_d = (lenClamped < 11'd15) ? MIN_LAST : OPC_LAST + lenClamped;
                    state_d   = CSUM1;
                end
            end
            CSUM1: begin
                sum_d   = 32'h0000_4500 + {16'd0, ipLen_q} + {16'd0, ipId_q}
                        + 32'h0000_4000 + 32'h0000_4011
                        + {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]}
                        + {16'd0, DST_IP[31:16]} + {16'd0, DST_IP[15:0]};
                state_d = CSUM2;
            end
            CSUM2: begin
                csum_d  = ~fold2;
                cnt_d   = '0;
                state_d = HDR;
            end
            HDR: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tdata  = hdrByte;
                if (bus.m_axis_tready) begin
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q == HDR_LAST) state_d = OPC;
                end
            end
            OPC: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tdata  = opcByte;
                if (bus.m_axis_tready) begin
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q == OPC_LAST) state_d = (nLen_q == 11'd0) ? PAD : PAYLOAD;
                end
            end
            // An empty FIFO simply withholds tvalid; the frame resumes when data arrives.
            PAYLOAD: begin
                bus.m_axis_tvalid = !bus.fifo_empty;
                bus.m_axis_tdata  = bus.fifo_dout;
                bus.m_axis_tlast  = !bus.fifo_empty && (cnt_q == lastIdx_q);
                bus.fifo_rd_en    = !bus.fifo_empty && bus.m_axis_tready;
                if (!bus.fifo_empty && bus.m_axis_tready) begin
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q == lastIdx_q) begin
                        state_d = IDLE;
                        ipId_d  = ipId_q + 16'd1;
                    end else if (cnt_q == OPC_LAST + nLen_q) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tlast  = (cnt_q == lastIdx_q);
                if (bus.m_axis_tready) begin
                    cnt_d = cnt_q + 11'd1;
                    if (cnt_q == lastIdx_q) begin
                        state_d = IDLE;
                        ipId_d  = ipId_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_udp_payload_framer.sv
// Bench for udp_payload_framer: table of directed frames, random frames with random tready,
// and hand-written reset/stall sequences, all compared against a byte-image frame model.
module tb_udp_payload_framer;
    localparam logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC  = 48'h0200_0000_0032;
    localparam logic [47:0] SRC_IP   = {16'd0, 8'd192, 8'd168, 8'd1, 8'd50};
    localparam logic [47:0] DST_IP   = {16'd0, 8'd192, 8'd168, 8'd1, 8'd10};
    localparam logic [47:0] SRC_PORT = 48'd55556;
    localparam logic [47:0] DST_PORT = 48'd55555;
    localparam logic [47:0] OPCODE   = 48'hA0B0C0;

    typedef struct {
        int reqLen;
        int nEff;
        int frameLen;
        int ipLen;
        int udpLen;
        int pattern;
        bit randReady;
        int preload;
        int lateDelay;
        bit midStart;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    udp_payload_framer_if ifc();

    udp_payload_framer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // FWFT FIFO: the bench owns the write pointer, the pop side follows fifo_rd_en.
    logic [7:0] fifoMem [0:4095];
    int rdIdx = 0;
    int wrIdx = 0;
    assign ifc.fifo_empty = (rdIdx == wrIdx);
    assign ifc.fifo_dout  = fifoMem[rdIdx[11:0]];
    always @(posedge clk) if (ifc.fifo_rd_en && rdIdx != wrIdx) rdIdx <= rdIdx + 1;

    logic [7:0]  capQ[$];
    bit          lastQ[$];
    logic [7:0]  payQ[$];
    logic [7:0]  expQ[$];
    logic [7:0]  lateQ[$];
    int          lateAt;
    int          cycle = 0;
    int          rdPulses;
    int          stabErr = 0;
    bit          randReady = 1'b0;
    bit          prevStall = 1'b0;
    logic [7:0]  prevData;
    bit          prevLast;
    logic [15:0] expId = 16'h0000;
    vec_t        tbl[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushFifo(input logic [7:0] b);
        fifoMem[wrIdx[11:0]] = b;
        wrIdx++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        ifc.start = 1'b0;
        if (lateQ.size() != 0 && cycle == lateAt) begin
            foreach (lateQ[i]) pushFifo(lateQ[i]);
            lateQ.delete();
        end
        ifc.m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prevStall && !rst) begin
            if (!ifc.m_axis_tvalid || ifc.m_axis_tdata != prevData || ifc.m_axis_tlast != prevLast)
                stabErr++;
        end
        if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
            capQ.push_back(ifc.m_axis_tdata);
            lastQ.push_back(ifc.m_axis_tlast);
        end
        if (ifc.fifo_rd_en) rdPulses++;
        prevStall = ifc.m_axis_tvalid && !ifc.m_axis_tready;
        prevData  = ifc.m_axis_tdata;
        prevLast  = ifc.m_axis_tlast;
    endtask

    task automatic pushField(input logic [47:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) expQ.push_back(8'(v >> (8 * i)));
    endtask

    // Reference frame image: header with zero checksum, opcode, payload, pad, then checksum patched in.
    task automatic buildExpected(input int n, input logic [15:0] id);
        int sum;
        logic [15:0] csum;
        expQ.delete();
        pushField(DST_MAC, 6);
        pushField(SRC_MAC, 6);
        pushField(48'h0800, 2);
        pushField(48'h45, 1);
        pushField(48'h00, 1);
        pushField(48'(20 + 8 + 3 + n), 2);
        pushField({32'd0, id}, 2);
        pushField(48'h4000, 2);
        pushField(48'h40, 1);
        pushField(48'h11, 1);
        pushField(48'h0, 2);
        pushField(SRC_IP, 4);
        pushField(DST_IP, 4);
        pushField(SRC_PORT, 2);
        pushField(DST_PORT, 2);
        pushField(48'(8 + 3 + n), 2);
        pushField(48'h0, 2);
        pushField(OPCODE, 3);
        for (int i = 0; i < n; i++) expQ.push_back(payQ[i]);
        while (expQ.size() < 60) expQ.push_back(8'h00);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += {expQ[i], expQ[i + 1]};
        while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
        csum = ~sum[15:0];
        expQ[24] = csum[15:8];
        expQ[25] = csum[7:0];
    endtask

    task automatic applyStimulus(input vec_t v);
        int startCycle;
        int firstValid;
        int gapBytes;
        bit gapValid;
        bit done;
        int nBad;
        int badIdx;
        int nLast;
        int lastPos;
        int sum;
        payQ.delete();
        capQ.delete();
        lastQ.delete();
        lateQ.delete();
        rdPulses = 0;
        for (int i = 0; i < v.nEff; i++) begin
            case (v.pattern)
                0:       payQ.push_back(8'($urandom));
                1:       payQ.push_back(8'(i));
                default: payQ.push_back(8'(8'h11 * (i + 1)));
            endcase
        end
        for (int i = 0; i < v.nEff; i++) begin
            if (i < v.preload) pushFifo(payQ[i]);
            else lateQ.push_back(payQ[i]);
        end
        buildExpected(v.nEff, expId);
        randReady = v.randReady;
        startCycle = cycle;
        lateAt = startCycle + 50 + v.lateDelay;
        ifc.payload_len = 11'(v.reqLen);
        ifc.start = 1'b1;
        firstValid = -1;
        gapBytes = -1;
        gapValid = 1'b1;
        done = 1'b0;
        for (int t = 1; t <= 8000 && !done; t++) begin
            tick();
            if (firstValid < 0 && ifc.m_axis_tvalid) firstValid = t;
            if (v.midStart && t == 20) begin
                ifc.payload_len = 11'd5;
                ifc.start = 1'b1;
            end
            if (v.lateDelay > 0 && cycle == lateAt - 1) begin
                gapBytes = capQ.size();
                gapValid = ifc.m_axis_tvalid;
            end
            if (lastQ.size() != 0 && lastQ[lastQ.size() - 1]) done = 1'b1;
        end
        checkOutput("frameCompleted", int'(done), 1);
        randReady = 1'b0;
        tick();
        checkOutput("busyAfterTlast", int'(ifc.busy), 0);
        checkOutput("firstValidLatency", firstValid, 3);
        checkOutput("frameLen", capQ.size(), v.frameLen);
        checkOutput("modelLen", expQ.size(), v.frameLen);
        nBad = 0;
        badIdx = -1;
        for (int i = 0; i < capQ.size() && i < expQ.size(); i++) begin
            if (capQ[i] !== expQ[i]) begin
                if (badIdx < 0) badIdx = i;
                nBad++;
            end
        end
        if (badIdx >= 0)
            $display("[TB] first differing byte %0d: got %02h want %02h", badIdx, capQ[badIdx], expQ[badIdx]);
        checkOutput("frameByteMismatches", nBad, 0);
        nLast = 0;
        lastPos = -1;
        foreach (lastQ[i]) if (lastQ[i]) begin nLast++; lastPos = i; end
        checkOutput("tlastCount", nLast, 1);
        checkOutput("tlastPos", lastPos, v.frameLen - 1);
        checkOutput("fifoRdPulses", rdPulses, v.nEff);
        if (capQ.size() >= 40) begin
            checkOutput("ipLen", {capQ[16], capQ[17]}, v.ipLen);
            checkOutput("ipId", {capQ[18], capQ[19]}, int'(expId));
            checkOutput("udpLen", {capQ[38], capQ[39]}, v.udpLen);
            sum = 0;
            for (int i = 14; i < 34; i += 2) sum += {capQ[i], capQ[i + 1]};
            while (sum > 'hFFFF) sum = (sum & 'hFFFF) + (sum >> 16);
            checkOutput("ipHdrOnesSum", sum, 'hFFFF);
        end
        if (v.lateDelay > 0) begin
            checkOutput("bytesBeforeGap", gapBytes, 48);
            checkOutput("tvalidInGap", int'(gapValid), 0);
        end
        if (v.midStart) begin
            tick();
            tick();
            tick();
            checkOutput("midStartNotQueued", int'(ifc.busy || ifc.m_axis_tvalid), 0);
        end
        expId = expId + 16'd1;
    endtask

    initial begin
        vec_t v;
        int nLast;
        bit reached;
        //            req   nEff frame ipLen   udpLen  pat rnd pre   late mid
        tbl[0] = '{   4,    4,   60, 'h023,  'h00F,  2,  0,    4,  0,  0};
        tbl[1] = '{ 100,  100,  145, 'h083,  'h06F,  1,  0,  100,  0,  0};
        tbl[2] = '{  20,   20,   65, 'h033,  'h01F,  0,  1,   20,  0,  0};
        tbl[3] = '{   8,    8,   60, 'h027,  'h013,  0,  0,    3, 20,  0};
        tbl[4] = '{   0,    0,   60, 'h01F,  'h00B,  0,  0,    0,  0,  1};
        tbl[5] = '{  15,   15,   60, 'h02E,  'h01A,  0,  0,   15,  0,  0};
        tbl[6] = '{  16,   16,   61, 'h02F,  'h01B,  0,  0,   16,  0,  0};
        tbl[7] = '{2000, 1469, 1514, 'h5DC,  'h5C8,  0,  0, 1469,  0,  0};

        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.payload_len = 11'd0;
        ifc.m_axis_tready = 1'b1;
        tick();
        tick();
        checkOutput("resetBusy", int'(ifc.busy), 0);
        checkOutput("resetTvalid", int'(ifc.m_axis_tvalid), 0);
        checkOutput("resetTlast", int'(ifc.m_axis_tlast), 0);
        checkOutput("resetTdata", int'(ifc.m_axis_tdata), 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            $display("[TB] vector %0d: N=%0d", k, tbl[k].reqLen);
            applyStimulus(tbl[k]);
            tick();
        end

        for (int k = 0; k < 6; k++) begin
            v.reqLen    = int'($urandom_range(0, 80));
            v.nEff      = v.reqLen;
            v.frameLen  = (v.nEff + 45 < 60) ? 60 : v.nEff + 45;
            v.ipLen     = 20 + 8 + 3 + v.nEff;
            v.udpLen    = 8 + 3 + v.nEff;
            v.pattern   = 0;
            v.randReady = 1'b1;
            v.preload   = v.nEff;
            v.lateDelay = 0;
            v.midStart  = 1'b0;
            $display("[TB] random frame %0d: N=%0d", k, v.nEff);
            applyStimulus(v);
        end

        // Reset in the middle of a frame truncates it and clears the IP identification.
        payQ.delete();
        capQ.delete();
        lastQ.delete();
        for (int i = 0; i < 40; i++) pushFifo(8'($urandom));
        ifc.payload_len = 11'd40;
        ifc.start = 1'b1;
        reached = 1'b0;
        for (int t = 0; t < 200 && !reached; t++) begin
            tick();
            if (capQ.size() >= 30) reached = 1'b1;
        end
        checkOutput("reachedByte30", int'(reached), 1);
        rst = 1'b1;
        tick();
        checkOutput("rstMidTvalid", int'(ifc.m_axis_tvalid), 0);
        checkOutput("rstMidBusy", int'(ifc.busy), 0);
        rst = 1'b0;
        nLast = 0;
        foreach (lastQ[i]) if (lastQ[i]) nLast++;
        checkOutput("rstMidNoTlast", nLast, 0);
        wrIdx = rdIdx;
        expId = 16'h0000;
        tick();
        applyStimulus(tbl[0]);

        checkOutput("stableDuringStalls", stabErr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
